display_rx: RTL and testbench

DISPLAY_RX -- requirements
Module: display_rx

---
 rtl/display_rx.sv | 155 +++++++++++++++
 tb/tb_display_rx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_rx.sv
// Parallel-RGB display receiver: recovers pixel coordinates from vsync/de timing,
// measures the incoming frame format and emits pixels only once the format is locked.
module display_rx #(
    parameter int EXP_WIDTH   = 480,
    parameter int EXP_HEIGHT  = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    input  logic [15:0] color,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] pix_color,
    output logic        sof,
    output logic [9:0]  meas_width,
    output logic [9:0]  meas_height,
    output logic        locked,
    output logic        err
);

    localparam logic [1:0] SEEK   = 2'd0;
    localparam logic [1:0] VBLANK = 2'd1;
    localparam logic [1:0] LINE   = 2'd2;
    localparam logic [1:0] HBLANK = 2'd3;

    localparam logic [9:0] W_EXP   = 10'(EXP_WIDTH);
    localparam logic [9:0] H_EXP   = 10'(EXP_HEIGHT);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    logic        hsync_s1, vsync_s1, de_s1;
    logic [15:0] color_s1;
    logic        vsync_d, de_d;
    logic [1:0]  state;
    logic [9:0]  x_cnt, line_cnt;
    logic [3:0]  good_cnt, good_next;

    logic       vs_fall, de_rise, de_fall, in_blank;
    logic       line_end, truncated, frame_chk;
    logic       width_bad, height_bad, err_now, pixel_now;
    logic [9:0] lines_now, pix_x_now;
    logic       unused_sync;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    // hsync is captured for timing alignment only; line structure comes from de.
    assign unused_sync = hsync_s1;

    assign vs_fall  = vsync_d & ~vsync_s1;
    assign de_rise  = de_s1 & ~de_d;
    assign de_fall  = de_d & ~de_s1;
    assign in_blank = (state == VBLANK) || (state == HBLANK);

    // A line closing in the same cycle as vsync falls is a normal line end, not a truncation.
    assign line_end   = (state == LINE) && de_fall;
    assign truncated  = vs_fall && (state == LINE) && !de_fall;
    assign frame_chk  = vs_fall && (in_blank || line_end);
    assign lines_now  = line_end ? sat_inc(line_cnt) : line_cnt;
    assign width_bad  = line_end && (x_cnt != W_EXP);
    assign height_bad = frame_chk && (lines_now != H_EXP);
    assign err_now    = width_bad || height_bad || truncated;

    assign pixel_now = !vs_fall && de_s1 && ((state == LINE) || (in_blank && de_rise));
    assign pix_x_now = (state == LINE) ? x_cnt : 10'd0;

    assign locked = (good_cnt == LOCK_N);

    always_comb begin
        // NOTE: default assigned first so no path through this block infers a latch.
        good_next = good_cnt;
        if (err_now)
            good_next = '0;
        else if (frame_chk && good_cnt != LOCK_N)
            good_next = good_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Sync bits idle high so the first cycle after reset never sees a false vsync edge.
            hsync_s1    <= 1'b1;
            vsync_s1    <= 1'b1;
            vsync_d     <= 1'b1;
            de_s1       <= 1'b0;
            de_d        <= 1'b0;
            color_s1    <= '0;
            state       <= SEEK;
            x_cnt       <= '0;
            line_cnt    <= '0;
            good_cnt    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_color   <= '0;
            sof         <= 1'b0;
            err         <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its peers.
            hsync_s1 <= hsync;
            vsync_s1 <= vsync;
            de_s1    <= de;
            color_s1 <= color;
            vsync_d  <= vsync_s1;
            de_d     <= de_s1;

            sof      <= vs_fall;
            err      <= err_now;
            good_cnt <= good_next;

            if (line_end)
                meas_width <= x_cnt;
            if (frame_chk)
                meas_height <= lines_now;

            pix_valid <= locked && pixel_now && (pix_x_now < W_EXP) && (line_cnt < H_EXP);
            if (locked && pixel_now && (pix_x_now < W_EXP) && (line_cnt < H_EXP)) begin
                pix_x     <= pix_x_now;
                pix_y     <= line_cnt;
                pix_color <= color_s1;
            end

            if (vs_fall) begin
                state    <= VBLANK;
                x_cnt    <= '0;
                line_cnt <= '0;
            end else begin
                case (state)
                    VBLANK, HBLANK: begin
                        if (de_rise) begin
                            state <= LINE;
                            x_cnt <= 10'd1;
                        end
                    end
                    LINE: begin
                        if (de_fall) begin
                            state    <= HBLANK;
                            line_cnt <= lines_now;
                        end else begin
                            x_cnt <= sat_inc(x_cnt);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_rx.sv
// Self-checking bench for display_rx: frame-level reference model with a pixel
// scoreboard, a table of frame formats, and hand sequences for truncation and reset.
module tb_display_rx;

    localparam int EW = 8;
    localparam int EH = 6;
    localparam int LK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b1, vsync = 1'b1, de = 1'b0;
    logic [15:0] color = '0;
    logic        pix_valid, sof, locked, err;
    logic [9:0]  pix_x, pix_y, meas_width, meas_height;
    logic [15:0] pix_color;

    display_rx #(.EXP_WIDTH(EW), .EXP_HEIGHT(EH), .LOCK_FRAMES(LK)) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de), .color(color),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .sof(sof), .meas_width(meas_width), .meas_height(meas_height),
        .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] c;
        int          cyc;
    } pix_t;

    typedef struct {
        int n_lines;
        int bad_idx;
        int bad_w;
        int tight;
        int exp_locked;
        int exp_mh;
        int exp_mw;
    } frame_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   cyc = 0;

    // Reference model state, tracked per line and per frame.
    int m_good = 0;
    int m_seek = 1;
    int m_lines = 0;
    int m_last_bad = 0;
    int m_err = 0;
    int m_sof = 0;

    int err_seen = 0, sof_seen = 0, pix_seen = 0;
    int err_lock = 0, err_multi = 0, hold_viol = 0;
    logic        prev_err = 1'b0;
    logic [35:0] last_out = '0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            if (err) err_seen++;
            if (sof) sof_seen++;
            if (err && locked) err_lock++;
            if (err && prev_err) err_multi++;
            if (pix_valid) begin
                pix_seen++;
                if (exp_q.size() == 0) begin
                    check("pix_extra", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixel", 64'({pix_x, pix_y, pix_color, 16'(cyc)}),
                          64'({mon_e.x, mon_e.y, mon_e.c, 16'(mon_e.cyc)}));
                end
            end else if ({pix_x, pix_y, pix_color} != last_out) begin
                hold_viol++;
            end
        end
        prev_err = err;
        last_out = {pix_x, pix_y, pix_color};
    end

    task automatic tick(input logic h, input logic v, input logic d, input logic [15:0] c);
        @(negedge clk);
        hsync = h;
        vsync = v;
        de    = d;
        color = c;
    endtask

    task automatic hblank();
        for (int i = 0; i < 3; i++) tick((i != 1), 1'b1, 1'b0, 16'h0);
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] c;
            c = 16'($urandom);
            tick(1'b1, 1'b1, 1'b1, c);
            if (m_seek == 0 && m_good == LK && i < EW && m_lines < EH)
                exp_q.push_back('{x: 10'(i), y: 10'(m_lines), c: c, cyc: cyc + 2});
        end
    endtask

    task automatic line(input int w);
        hblank();
        pixels(w);
        if (m_seek == 0) begin
            m_lines++;
            m_last_bad = (w != EW) ? 1 : 0;
            if (w != EW) begin
                m_err++;
                m_good = 0;
            end
        end
    endtask

    // tight=1 drops vsync in the very cycle de falls after the last line.
    task automatic vs_edge(input int tight);
        if (tight == 0) begin
            tick(1'b1, 1'b1, 1'b0, 16'h0);
            tick(1'b1, 1'b1, 1'b0, 16'h0);
        end
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        m_sof++;
        if (m_seek != 0) begin
            m_seek = 0;
        end else if (m_lines != EH) begin
            if (!(tight != 0 && m_last_bad != 0)) m_err++;
            m_good = 0;
        end else if (tight != 0 && m_last_bad != 0) begin
            m_good = 0;
        end else if (m_good < LK) begin
            m_good++;
        end
        m_lines = 0;
        tick(1'b1, 1'b0, 1'b0, 16'h0);
        @(posedge clk) #1;
        check("sof_pulse", 64'(sof), 64'd1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic trunc(input int n);
        hblank();
        pixels(n);
        tick(1'b1, 1'b0, 1'b1, 16'h1234);
        m_err++;
        m_good = 0;
        m_lines = 0;
        m_sof++;
        tick(1'b1, 1'b0, 1'b1, 16'h1234);
        @(posedge clk) #1;
        check("trunc_err_pulse", 64'(err), 64'd1);
        tick(1'b1, 1'b1, 1'b0, 16'h0);
        @(posedge clk) #1;
        check("trunc_err_single", 64'(err), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({pix_valid, pix_x, pix_y, pix_color, sof, meas_width, meas_height, locked, err});
    endfunction

    frame_t tbl[10];
    int     err_base;

    initial begin
        //           lines bad  w   tight lock mh mw
        tbl[0] = '{6, -1, 0, 0, 0, 6, 8};
        tbl[1] = '{6, -1, 0, 0, 1, 6, 8};
        tbl[2] = '{6, -1, 0, 0, 1, 6, 8};
        tbl[3] = '{6,  5, 7, 0, 0, 6, 7};
        tbl[4] = '{6, -1, 0, 0, 1, 6, 8};
        tbl[5] = '{7, -1, 0, 0, 0, 7, 8};
        tbl[6] = '{6, -1, 0, 0, 0, 6, 8};
        tbl[7] = '{5,  4, 9, 1, 0, 5, 9};
        tbl[8] = '{6, -1, 0, 0, 0, 6, 8};
        tbl[9] = '{6, -1, 0, 0, 1, 6, 8};

        repeat (3) @(negedge clk);
        @(posedge clk) #1;
        check("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Activity before any vsync edge must be ignored.
        for (int l = 0; l < 3; l++) line(EW);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 16'h0);
        check("seek_no_err", 64'(err_seen), 64'd0);
        check("seek_no_pix", 64'(pix_seen), 64'd0);
        check("seek_meas_width", 64'(meas_width), 64'd0);

        vs_edge(0);
        check("first_vs_unlocked", 64'(locked), 64'd0);

        for (int k = 0; k < 10; k++) begin
            for (int l = 0; l < tbl[k].n_lines; l++)
                line((l == tbl[k].bad_idx) ? tbl[k].bad_w : EW);
            vs_edge(tbl[k].tight);
            check($sformatf("f%0d_locked", k), 64'(locked), 64'(tbl[k].exp_locked));
            check($sformatf("f%0d_meas_height", k), 64'(meas_height), 64'(tbl[k].exp_mh));
            check($sformatf("f%0d_meas_width", k), 64'(meas_width), 64'(tbl[k].exp_mw));
        end

        // Vsync falling in the middle of an active line while locked.
        for (int l = 0; l < EH; l++) line(EW);
        trunc(4);
        check("trunc_unlocked", 64'(locked), 64'd0);
        check("trunc_meas_width", 64'(meas_width), 64'(EW));
        check("trunc_meas_height", 64'(meas_height), 64'(EH));

        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < EH; l++) line(EW);
            vs_edge(0);
        end
        check("relock_after_trunc", 64'(locked), 64'd1);

        // Reset in the middle of a line while locked.
        hblank();
        pixels(4);
        @(negedge clk);
        rst = 1'b1;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        err_base = err_seen;
        m_seek = 1;
        m_good = 0;
        m_lines = 0;
        @(posedge clk) #1;
        check("midline_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        de  = 1'b0;
        rst = 1'b0;

        vs_edge(0);
        check("post_reset_unlocked", 64'(locked), 64'd0);
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < EH; l++) line(EW);
            vs_edge(0);
            check($sformatf("relock_frame%0d", f), 64'(locked), 64'(f));
        end
        check("post_reset_no_err", 64'(err_seen), 64'(err_base));
        for (int l = 0; l < 2; l++) line(EW);
        repeat (6) tick(1'b1, 1'b1, 1'b0, 16'h0);

        check("pix_missing", 64'(exp_q.size()), 64'd0);
        check("err_count", 64'(err_seen), 64'(m_err));
        check("sof_count", 64'(sof_seen), 64'(m_sof));
        check("err_while_locked", 64'(err_lock), 64'd0);
        check("err_multi_cycle", 64'(err_multi), 64'd0);
        check("pix_hold", 64'(hold_viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
